uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Shares the single board UART transmitter (driving `uart_rxd_out`) between several byte-stream requesters, e.g. the switch-event reporter fed by the debounce/edge-detect path and the CPU debug console. Round-robin arbitration at packet granularity: a requester keeps the transmitter until it sends a beat marked `last`, or until a configurable burst limit forces release. Sits between the requesters and the UART TX serializer, all in the `clk` (main) domain.

## Interface

- `NumReq`, default 2: number of requesters, 2..8.
- `MaxBurst`, default 0: beats per grant before forced release; 0 = unlimited.
- `clk`  in  1  main system clock; all logic on rising edge.
- `rst_n`  in  1  reset: one clock; reset is synchronous and active-low.
- `req_valid`  in  NumReq  requester i presents a byte.
- `req_data`  in  NumReq x 8  byte from requester i.
- `req_last`  in  NumReq  byte is last of requester i's packet.
- `req_ready`  out  NumReq  byte from requester i accepted this cycle.
- `tx_valid`  out  1  byte presented to UART serializer.
- `tx_data`  out  8  byte to serializer.
- `tx_ready`  in  1  serializer accepts byte this cycle.
- `grant_id`  out  $clog2(NumReq)  current owner; valid when `busy`.
- `busy`  out  1  a requester holds the grant.

## Operation

- States: IDLE, OWNED.
- IDLE: `tx_valid`=0, all `req_ready`=0. If any `req_valid`, select winner = first asserted index scanning upward from `rr_ptr` with wrap-around; register `grant_id`=winner, clear `beat_cnt`, go to OWNED. No request: stay.
- OWNED: pass-through from owner: `tx_valid`=`req_valid[grant_id]`, `tx_data`=`req_data[grant_id]`, `req_ready[grant_id]`=`tx_ready`; all other `req_ready`=0. Beat = `tx_valid && tx_ready`.
- On each beat: `beat_cnt`+1 (saturating, width $clog2(MaxBurst+1), min 1).
- Release after a beat if `req_last[grant_id]`=1, or `MaxBurst`≠0 and this beat is beat number `MaxBurst`. On release: `rr_ptr` = (`grant_id`+1) mod `NumReq`, go to IDLE.
- Owner deasserting `req_valid` mid-packet: grant held, no timeout; `tx_valid` follows `req_valid`.
- Non-owner requests wait; their `req_valid`/`req_data` must stay stable until accepted (standard valid/ready).
- `tx_data` when `tx_valid`=0: don't-care, implemented as 8'h00.

## Timing

- Reset (`rst_n`=0 at a rising edge): state IDLE, `rr_ptr`=0, `grant_id`=0, `beat_cnt`=0, `busy`=0, `tx_valid`=0, `req_ready`=0, `tx_data`=8'h00. Reset mid-packet aborts the packet; no partial beat completes in the reset cycle.
- Arbitration latency: request seen in IDLE at cycle N -> OWNED and `tx_valid` at cycle N+1 (one-cycle bubble per grant).
- Data path combinational from owner inputs to `tx_*` and from `tx_ready` to `req_ready`; no added latency within a packet; back-to-back beats at one per cycle.
- Release beat at cycle N -> IDLE at N+1 -> next owner at N+2. The releasing requester is lowest priority at N+1.
- Simultaneous `req_last` and burst limit on the same beat: single release, identical effect.
- `busy`=1 exactly in OWNED; `grant_id` changes only on IDLE->OWNED.

## Structure

- Package `uart_arb_pkg`: `arb_state_e` (IDLE, OWNED), `byte_t` (logic [7:0]), `MAX_REQ` = 8.
- Sub-module `rr_picker`: combinational; inputs request vector + `rr_ptr`, outputs `any` and winner index. Parameterised by `NumReq`; reusable for other shared resources.
- Top of block: state register, `rr_ptr`, `grant_id`, `beat_cnt`, output muxes.

## Test plan

- Reset: hold `rst_n`=0 with all `req_valid`=1 -> `tx_valid`=0, `req_ready`=0, `busy`=0; release -> owner 0 one cycle later.
- Single packet: req 1 sends 8'h48, 8'h69 (last), `tx_ready`=1 -> `tx_data` 8'h48 then 8'h69 on consecutive cycles, `busy` drops cycle after 8'h69.
- Fairness: both requesters hold 3-byte packets continuously -> grants alternate 0,1,0,1; no interleaving within a packet.
- Backpressure: `tx_ready`=0 for 5 cycles mid-packet -> `tx_data` stable, owner `req_ready`=0, other requester never accepted.
- Burst limit: `MaxBurst`=4, req 0 sends 10 bytes without last, req 1 waiting -> release after byte 4, req 1 packet served, req 0 resumes with byte 5.
- Reset mid-packet: assert `rst_n`=0 after 2 of 5 bytes -> next cycle IDLE, `rr_ptr`=0, no extra beat on `tx_*`.

Source files
------------

// File: rtl/uart_arb_pkg.sv
// Shared types for the UART transmitter arbiter and related shared-resource logic.
// Latency: none (declarations only).
// Backpressure: not applicable.
package uart_arb_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } arb_state_e;

    typedef logic [7:0] byte_t;

    localparam int MAX_REQ = 8;

endpackage

// File: rtl/rr_picker.sv
// Round-robin picker: first asserted request at or above rr_ptr, wrapping around.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the pick is consumed.
module rr_picker #(
    parameter int NumReq = 2,
    localparam int IdW = (NumReq > 1) ? $clog2(NumReq) : 1
) (
    input  logic [NumReq-1:0] req,
    input  logic [IdW-1:0]    rr_ptr,
    output logic              any,
    output logic [IdW-1:0]    winner
);

    // Scan offsets from high to low so the smallest offset from rr_ptr is written last and wins.
    always_comb begin
        int idx;
        winner = '0;
        idx    = 0;
        for (int i = NumReq - 1; i >= 0; i--) begin
            idx = int'(rr_ptr) + i;
            if (idx >= NumReq) begin
                idx = idx - NumReq;
            end
            if (req[idx]) begin
                winner = IdW'(idx);
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART TX serializer between NumReq byte streams, round-robin per packet.
// Latency: one idle cycle per grant; beats within a packet pass through combinationally.
// Backpressure: tx_ready routed straight to the owner's req_ready; non-owners stall.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NumReq   = 2,
    parameter int MaxBurst = 0,
    localparam int GidW    = $clog2(NumReq)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NumReq-1:0]       req_valid,
    input  byte_t [NumReq-1:0]      req_data,
    input  logic [NumReq-1:0]       req_last,
    output logic [NumReq-1:0]       req_ready,
    output logic                    tx_valid,
    output byte_t                   tx_data,
    input  logic                    tx_ready,
    output logic [GidW-1:0]         grant_id,
    output logic                    busy
);

    // Beat counter is at least one bit wide even when bursts are unlimited.
    localparam int CntW      = (MaxBurst > 0) ? $clog2(MaxBurst + 1) : 1;
    localparam int BurstLast = (MaxBurst > 0) ? MaxBurst - 1 : 0;

    arb_state_e      state, state_nxt;
    logic [GidW-1:0] rr_ptr, rr_ptr_nxt;
    logic [GidW-1:0] grant_nxt;
    logic [CntW-1:0] beat_cnt, beat_cnt_nxt;

    logic            pick_any;
    logic [GidW-1:0] pick_id;
    logic            beat;
    logic            burst_hit;

    rr_picker #(
        .NumReq (NumReq)
    ) u_picker (
        .req    (req_valid),
        .rr_ptr (rr_ptr),
        .any    (pick_any),
        .winner (pick_id)
    );

    // Arbitration state, grant owner, pointer and beat count; reset aborts any open packet.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            grant_id <= '0;
            beat_cnt <= '0;
        end else begin
            state    <= state_nxt;
            rr_ptr   <= rr_ptr_nxt;
            grant_id <= grant_nxt;
            beat_cnt <= beat_cnt_nxt;
        end
    end

    // Next-state and owner pass-through; outputs are forced quiet while reset is asserted
    // so an owned packet cannot complete a beat in the reset cycle.
    always_comb begin
        state_nxt    = state;
        rr_ptr_nxt   = rr_ptr;
        grant_nxt    = grant_id;
        beat_cnt_nxt = beat_cnt;
        tx_valid     = 1'b0;
        tx_data      = 8'h00;
        req_ready    = '0;
        beat         = 1'b0;
        burst_hit    = 1'b0;

        case (state)
            IDLE: begin
                if (pick_any) begin
                    grant_nxt    = pick_id;
                    beat_cnt_nxt = '0;
                    state_nxt    = OWNED;
                end
            end
            OWNED: begin
                if (rst_n) begin
                    tx_valid            = req_valid[grant_id];
                    tx_data             = tx_valid ? req_data[grant_id] : 8'h00;
                    req_ready[grant_id] = tx_ready;
                end
                beat      = tx_valid && tx_ready;
                burst_hit = (MaxBurst != 0) && (beat_cnt == CntW'(BurstLast));
                if (beat) begin
                    if (beat_cnt != {CntW{1'b1}}) begin
                        beat_cnt_nxt = beat_cnt + 1'b1;
                    end
                    // Either end-of-packet or burst limit hands the transmitter on;
                    // the releasing requester drops to lowest priority.
                    if (req_last[grant_id] || burst_hit) begin
                        if (int'(grant_id) == NumReq - 1) begin
                            rr_ptr_nxt = '0;
                        end else begin
                            rr_ptr_nxt = grant_id + 1'b1;
                        end
                        state_nxt = IDLE;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign busy = (state == OWNED);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with two requesters and a 4-beat burst limit.
// Latency: checks the one-cycle grant bubble and same-cycle pass-through.
// Backpressure: exercises tx_ready stalls and waiting non-owners.
module tb_uart_tx_arbiter;
    import uart_arb_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [1:0]  req_valid;
    byte_t [1:0] req_data;
    logic [1:0]  req_last;
    logic [1:0]  req_ready;
    logic        tx_valid;
    byte_t       tx_data;
    logic        tx_ready;
    logic [0:0]  grant_id;
    logic        busy;

    int n_tests;
    int n_fail;

    byte_t      exp_dat [12];
    logic [0:0] exp_gid [12];

    uart_tx_arbiter #(
        .NumReq   (2),
        .MaxBurst (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .tx_valid  (tx_valid),
        .tx_data   (tx_data),
        .tx_ready  (tx_ready),
        .grant_id  (grant_id),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        tx_ready  = 1'b0;
        next_cycle();
        next_cycle();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n       = 1'b0;
        req_valid   = 2'b11;
        req_data[0] = 8'hA5;
        req_data[1] = 8'h5A;
        req_last    = 2'b00;
        tx_ready    = 1'b1;
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            @(negedge clk);
            n_tests++;
            if (tx_valid !== 1'b0 || req_ready !== 2'b00 || busy !== 1'b0 || tx_data !== 8'h00) begin
                n_fail++;
                $display("FAIL reset_hold: tx_valid=%b req_ready=%b busy=%b tx_data=%h, want 0 00 0 00",
                         tx_valid, req_ready, busy, tx_data);
            end
        end
        tx_ready = 1'b0;
        next_cycle();
        rst_n = 1'b1;
        @(negedge clk);
        n_tests++;
        if (busy !== 1'b0 || tx_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release_idle: busy=%b tx_valid=%b, want 0 0", busy, tx_valid);
        end
        next_cycle();
        @(negedge clk);
        n_tests++;
        if (busy !== 1'b1 || grant_id !== 1'b0 || tx_valid !== 1'b1 || tx_data !== 8'hA5) begin
            n_fail++;
            $display("FAIL reset_first_owner: busy=%b grant=%0d tx_valid=%b tx_data=%h, want 1 0 1 a5",
                     busy, grant_id, tx_valid, tx_data);
        end
    endtask

    task automatic test_single_packet();
        do_reset();
        tx_ready    = 1'b1;
        req_valid   = 2'b10;
        req_data[1] = 8'h48;
        req_last    = 2'b00;
        @(negedge clk);
        n_tests++;
        if (busy !== 1'b0 || tx_valid !== 1'b0 || req_ready !== 2'b00) begin
            n_fail++;
            $display("FAIL single_bubble: busy=%b tx_valid=%b req_ready=%b, want 0 0 00", busy, tx_valid, req_ready);
        end
        next_cycle();
        @(negedge clk);
        n_tests++;
        if (tx_valid !== 1'b1 || tx_data !== 8'h48 || req_ready !== 2'b10 || grant_id !== 1'b1) begin
            n_fail++;
            $display("FAIL single_byte0: tx_valid=%b tx_data=%h req_ready=%b grant=%0d, want 1 48 10 1",
                     tx_valid, tx_data, req_ready, grant_id);
        end
        next_cycle();
        req_data[1] = 8'h69;
        req_last    = 2'b10;
        @(negedge clk);
        n_tests++;
        if (tx_valid !== 1'b1 || tx_data !== 8'h69 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL single_byte1: tx_valid=%b tx_data=%h busy=%b, want 1 69 1", tx_valid, tx_data, busy);
        end
        next_cycle();
        req_valid = 2'b00;
        req_last  = 2'b00;
        @(negedge clk);
        n_tests++;
        if (busy !== 1'b0 || tx_valid !== 1'b0 || tx_data !== 8'h00) begin
            n_fail++;
            $display("FAIL single_release: busy=%b tx_valid=%b tx_data=%h, want 0 0 00", busy, tx_valid, tx_data);
        end
    endtask

    task automatic test_fairness();
        int cnt0, cnt1, nb, cyc;
        exp_dat = '{8'h00, 8'h01, 8'h02, 8'h10, 8'h11, 8'h12,
                    8'h03, 8'h04, 8'h05, 8'h13, 8'h14, 8'h15};
        exp_gid = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1,
                    1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        do_reset();
        tx_ready = 1'b1;
        cnt0 = 0; cnt1 = 0; nb = 0; cyc = 0;
        while (nb < 12 && cyc < 60) begin
            req_valid   = 2'b11;
            req_data[0] = {4'h0, 4'(cnt0)};
            req_data[1] = {4'h1, 4'(cnt1)};
            req_last[0] = (cnt0 % 3 == 2);
            req_last[1] = (cnt1 % 3 == 2);
            @(negedge clk);
            cyc++;
            if (tx_valid && tx_ready) begin
                n_tests++;
                if (tx_data !== exp_dat[nb] || grant_id !== exp_gid[nb] || req_ready !== (2'b01 << grant_id)) begin
                    n_fail++;
                    $display("FAIL fair_beat%0d: data=%h grant=%0d req_ready=%b, want data=%h grant=%0d",
                             nb, tx_data, grant_id, req_ready, exp_dat[nb], exp_gid[nb]);
                end
                nb++;
            end
            if (req_ready[0]) cnt0++;
            if (req_ready[1]) cnt1++;
            next_cycle();
        end
        n_tests++;
        if (nb !== 12 || cyc !== 16) begin
            n_fail++;
            $display("FAIL fair_timing: beats=%0d cycles=%0d, want 12 16", nb, cyc);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        tx_ready    = 1'b1;
        req_valid   = 2'b11;
        req_data[0] = 8'hA0;
        req_data[1] = 8'hB0;
        req_last    = 2'b10;
        next_cycle();
        @(negedge clk);
        n_tests++;
        if (tx_data !== 8'hA0 || req_ready !== 2'b01) begin
            n_fail++;
            $display("FAIL bp_first: tx_data=%h req_ready=%b, want a0 01", tx_data, req_ready);
        end
        next_cycle();
        req_data[0] = 8'hA1;
        tx_ready    = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_tests++;
            if (tx_valid !== 1'b1 || tx_data !== 8'hA1 || req_ready !== 2'b00 || grant_id !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_stall%0d: tx_valid=%b tx_data=%h req_ready=%b grant=%0d, want 1 a1 00 0",
                         i, tx_valid, tx_data, req_ready, grant_id);
            end
            next_cycle();
        end
        tx_ready = 1'b1;
        @(negedge clk);
        n_tests++;
        if (tx_data !== 8'hA1 || req_ready !== 2'b01) begin
            n_fail++;
            $display("FAIL bp_resume: tx_data=%h req_ready=%b, want a1 01", tx_data, req_ready);
        end
        next_cycle();
        req_data[0] = 8'hA2;
        req_last    = 2'b11;
        @(negedge clk);
        n_tests++;
        if (tx_data !== 8'hA2 || req_ready !== 2'b01) begin
            n_fail++;
            $display("FAIL bp_last: tx_data=%h req_ready=%b, want a2 01", tx_data, req_ready);
        end
        next_cycle();
        req_valid = 2'b10;
        @(negedge clk);
        n_tests++;
        if (busy !== 1'b0 || tx_valid !== 1'b0 || req_ready !== 2'b00) begin
            n_fail++;
            $display("FAIL bp_gap: busy=%b tx_valid=%b req_ready=%b, want 0 0 00", busy, tx_valid, req_ready);
        end
        next_cycle();
        @(negedge clk);
        n_tests++;
        if (grant_id !== 1'b1 || tx_data !== 8'hB0 || req_ready !== 2'b10) begin
            n_fail++;
            $display("FAIL bp_other: grant=%0d tx_data=%h req_ready=%b, want 1 b0 10", grant_id, tx_data, req_ready);
        end
        next_cycle();
        req_valid = 2'b00;
    endtask

    task automatic test_burst_limit();
        int cnt0, cnt1, nb, cyc;
        exp_dat = '{8'hC0, 8'hC1, 8'hC2, 8'hC3, 8'hD0, 8'hD1,
                    8'hC4, 8'hC5, 8'hC6, 8'hC7, 8'hC8, 8'hC9};
        exp_gid = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1,
                    1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        do_reset();
        tx_ready = 1'b1;
        cnt0 = 0; cnt1 = 0; nb = 0; cyc = 0;
        while (nb < 12 && cyc < 60) begin
            req_valid[0] = (cnt0 < 10);
            req_valid[1] = (cnt1 < 2);
            req_data[0]  = 8'hC0 + 8'(cnt0);
            req_data[1]  = 8'hD0 + 8'(cnt1);
            req_last[0]  = 1'b0;
            req_last[1]  = (cnt1 == 1);
            @(negedge clk);
            cyc++;
            if (tx_valid && tx_ready) begin
                n_tests++;
                if (tx_data !== exp_dat[nb] || grant_id !== exp_gid[nb]) begin
                    n_fail++;
                    $display("FAIL burst_beat%0d: data=%h grant=%0d, want data=%h grant=%0d",
                             nb, tx_data, grant_id, exp_dat[nb], exp_gid[nb]);
                end
                nb++;
            end
            if (req_ready[0]) cnt0++;
            if (req_ready[1]) cnt1++;
            next_cycle();
        end
        n_tests++;
        if (nb !== 12 || cyc !== 16) begin
            n_fail++;
            $display("FAIL burst_timing: beats=%0d cycles=%0d, want 12 16", nb, cyc);
        end
        req_valid = 2'b00;
    endtask

    task automatic test_reset_mid_packet();
        do_reset();
        tx_ready    = 1'b1;
        req_valid   = 2'b01;
        req_data[0] = 8'hF0;
        req_last    = 2'b01;
        next_cycle();
        next_cycle();
        req_data[0] = 8'hE0;
        req_last    = 2'b00;
        next_cycle();
        @(negedge clk);
        n_tests++;
        if (tx_data !== 8'hE0 || grant_id !== 1'b0 || req_ready !== 2'b01) begin
            n_fail++;
            $display("FAIL midrst_e0: tx_data=%h grant=%0d req_ready=%b, want e0 0 01", tx_data, grant_id, req_ready);
        end
        next_cycle();
        req_data[0] = 8'hE1;
        @(negedge clk);
        n_tests++;
        if (tx_data !== 8'hE1 || req_ready !== 2'b01) begin
            n_fail++;
            $display("FAIL midrst_e1: tx_data=%h req_ready=%b, want e1 01", tx_data, req_ready);
        end
        next_cycle();
        req_data[0] = 8'hE2;
        rst_n       = 1'b0;
        @(negedge clk);
        n_tests++;
        if (tx_valid !== 1'b0 || req_ready !== 2'b00 || tx_data !== 8'h00) begin
            n_fail++;
            $display("FAIL midrst_no_beat: tx_valid=%b req_ready=%b tx_data=%h, want 0 00 00",
                     tx_valid, req_ready, tx_data);
        end
        next_cycle();
        rst_n       = 1'b1;
        req_valid   = 2'b11;
        req_data[1] = 8'h77;
        req_last    = 2'b10;
        @(negedge clk);
        n_tests++;
        if (busy !== 1'b0 || tx_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_idle: busy=%b tx_valid=%b, want 0 0", busy, tx_valid);
        end
        next_cycle();
        @(negedge clk);
        n_tests++;
        if (busy !== 1'b1 || grant_id !== 1'b0 || tx_data !== 8'hE2) begin
            n_fail++;
            $display("FAIL midrst_ptr: busy=%b grant=%0d tx_data=%h, want 1 0 e2", busy, grant_id, tx_data);
        end
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        tx_ready  = 1'b0;
        #1;
        test_reset();
        test_single_packet();
        test_fairness();
        test_backpressure();
        test_burst_limit();
        test_reset_mid_packet();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
